// File: rtl/fifo_if_pkg.sv
// Shared types and Gray/binary helpers for the interface-unit asynchronous FIFO.
package fifo_if_pkg;

  localparam int unsigned FIFO_IF_ADDR_WIDTH = 4;
  localparam int unsigned PTR_MAX_W          = 32;

  typedef logic [FIFO_IF_ADDR_WIDTH:0] ptr_t;
  typedef logic [PTR_MAX_W-1:0]        ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  // Log-step prefix XOR from the MSB down; zero-extension does not disturb the result.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b = g;
    for (int unsigned s = 1; s < PTR_MAX_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_if_sync.sv
// Multi-bit flop-chain synchronizer with asynchronous active-high reset.
module fifo_if_sync #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_if_rptr_empty.sv
// Read-side pointer, empty flag and occupancy level for the async FIFO (rclk domain).
// Optional almost-empty output enabled by defining FIFO_IF_ALMOST_EMPTY_EN.
module fifo_if_rptr_empty
  import fifo_if_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH = FIFO_IF_ADDR_WIDTH,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned AE_THRESH       = 2
) (
  input  logic                     rclk,
  input  logic                     reset,
  input  logic                     rinc,
  input  logic [FIFO_ADDR_WIDTH:0] wptr_gray,
  output logic [FIFO_ADDR_WIDTH-1:0] raddr,
  output logic [FIFO_ADDR_WIDTH:0] rptr_gray,
  output logic                     rempty,
  output logic [FIFO_ADDR_WIDTH:0] rlevel,
`ifdef FIFO_IF_ALMOST_EMPTY_EN
  output logic                     ralmost_empty,
`endif
  output logic                     runderflow
);

  localparam int unsigned PW = FIFO_ADDR_WIDTH + 1;
  typedef logic [PW-1:0] rptr_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end
  if (AE_THRESH > (1 << FIFO_ADDR_WIDTH)) begin : g_bad_ae
    $error("AE_THRESH exceeds FIFO depth");
  end

  rptr_t rbin_q, rgray_q, rlevel_q;
  logic  rempty_q, runderflow_q;
  rptr_t wq_gray, wq_bin, rbin_d, rgray_d, rlevel_d;
  logic  ren;

  fifo_if_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk   (rclk),
    .reset (reset),
    .d_i   (wptr_gray),
    .q_o   (wq_gray)
  );

  always_comb begin
    ren      = rinc && !rempty_q;
    rbin_d   = rbin_q + rptr_t'(ren);
    rgray_d  = rptr_t'(bin2gray(ptr_wide_t'(rbin_d)));
    wq_bin   = rptr_t'(gray2bin(ptr_wide_t'(wq_gray)));
    rlevel_d = wq_bin - rbin_d;
  end

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      rbin_q       <= '0;
      rgray_q      <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rlevel_q <= rlevel_d;
      rempty_q <= (rgray_d == wq_gray);
      if (rinc && rempty_q) begin
        runderflow_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_IF_ALMOST_EMPTY_EN
  logic ralmost_empty_q;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      ralmost_empty_q <= 1'b1;
    end else begin
      ralmost_empty_q <= (32'(rlevel_d) <= AE_THRESH);
    end
  end

  assign ralmost_empty = ralmost_empty_q;
`endif

  assign raddr      = rbin_q[FIFO_ADDR_WIDTH-1:0];
  assign rptr_gray  = rgray_q;
  assign rempty     = rempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_if_rptr_empty.sv
// Self-checking bench for fifo_if_rptr_empty against a count-based reference model.
module tb_fifo_if_rptr_empty;

  localparam int AW    = 4;
  localparam int SYNC  = 2;
  localparam int AE    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 2 * DEPTH;

  logic          rclk = 1'b0;
  logic          reset;
  logic          rinc;
  logic [AW:0]   wptr_gray;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          rempty;
  logic [AW:0]   rlevel;
  logic          runderflow;
`ifdef FIFO_IF_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state: counts of words written (as driven) and popped.
  int wcount;
  int rcount;
  int whist[$];
  bit m_empty;
  bit m_under;
  int m_level;
  bit m_ae;

  always #5 rclk = ~rclk;

  fifo_if_rptr_empty #(
    .FIFO_ADDR_WIDTH (AW),
    .SYNC_STAGES     (SYNC),
    .AE_THRESH       (AE)
  ) dut (
    .rclk          (rclk),
    .reset         (reset),
    .rinc          (rinc),
    .wptr_gray     (wptr_gray),
    .raddr         (raddr),
    .rptr_gray     (rptr_gray),
    .rempty        (rempty),
    .rlevel        (rlevel),
`ifdef FIFO_IF_ALMOST_EMPTY_EN
    .ralmost_empty (ralmost_empty),
`endif
    .runderflow    (runderflow)
  );

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n % MOD);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rempty"},     32'(rempty),     32'(m_empty));
    check({tag, ".rlevel"},     32'(rlevel),     32'(m_level));
    check({tag, ".raddr"},      32'(raddr),      32'(rcount % DEPTH));
    check({tag, ".rptr_gray"},  32'(rptr_gray),  32'(to_gray(rcount)));
    check({tag, ".runderflow"}, 32'(runderflow), 32'(m_under));
`ifdef FIFO_IF_ALMOST_EMPTY_EN
    check({tag, ".ralmost_empty"}, 32'(ralmost_empty), 32'(m_ae));
`endif
  endtask

  task automatic model_reset();
    wcount  = 0;
    rcount  = 0;
    m_empty = 1'b1;
    m_under = 1'b0;
    m_level = 0;
    m_ae    = 1'b1;
    whist.delete();
    for (int i = 0; i < SYNC; i++) whist.push_back(0);
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input string tag, input bit pop);
    int seen;
    rinc      = pop;
    wptr_gray = to_gray(wcount);
    @(posedge rclk);
    seen = whist[SYNC-1];
    whist.push_front(wcount);
    void'(whist.pop_back());
    if (pop && !m_empty) rcount++;
    else if (pop) m_under = 1'b1;
    m_level = ((seen - rcount) % MOD + MOD) % MOD;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
    #1;
    check_all(tag);
  endtask

  initial begin
    int pops;
    reset = 1'b1;
    rinc = 1'b0;
    wptr_gray = '0;
    model_reset();
    #12;
    check_all("reset");
    reset = 1'b0;
    repeat (5) step("idle", 1'b0);

    // Single write, then wait for it to become visible, then pop it.
    wcount = 1;
    repeat (SYNC + 1) step("one_write", 1'b0);
    step("one_pop", 1'b1);
    check("one_pop.raddr1", 32'(raddr), 32'd1);

    // Fill to a full FIFO and drain it back-to-back.
    wcount = 17;
    repeat (SYNC + 1) step("fill", 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b1);

    // Streaming write/pop pairs across the pointer wrap.
    pops = 0;
    for (int i = 0; i < 48 && pops < 40; i++) begin
      if (wcount - rcount < DEPTH) wcount++;
      if (!m_empty) pops++;
      step("wrap", !m_empty);
    end
    repeat (SYNC + 2) step("wrap_tail", !m_empty);

    // Randomized mix of writes and pops (including pops while empty).
    for (int i = 0; i < 300; i++) begin
      if ((wcount - rcount < DEPTH) && ($urandom_range(0, 1) == 1)) wcount++;
      step("rand", 1'($urandom_range(0, 1)));
    end

    // Drain fully, then pop while empty.
    repeat (DEPTH + SYNC + 2) step("drain2", !m_empty);
    repeat (3) step("underflow", 1'b1);
    check("underflow.sticky", 32'(runderflow), 32'd1);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) begin
      if (wcount - rcount < DEPTH) wcount++;
      step("burst", 1'b1);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge rclk);
    reset = 1'b0;
    repeat (3) step("post_reset", 1'b0);

`ifdef FIFO_IF_ALMOST_EMPTY_EN
    wcount = 4;
    repeat (SYNC + 1) step("ae_fill", 1'b0);
    for (int i = 0; i < 5; i++) step("ae_drain", 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
